// File: rtl/bp_sacc_spm_arbiter_if.sv
// Requester-side bundle for the sacc scratchpad arbiter.
// Carries the host and accelerator request/response handshakes. The arbiter
// connects through the slave modport, and the requesters (or a bench) connect
// through the master modport.
interface bp_sacc_spm_arbiter_if #(
  parameter int width_p      = 64,
  parameter int addr_width_p = 16
);
  // Host IO path
  logic                    host_v_i;
  logic                    host_w_i;
  logic [addr_width_p-1:0] host_addr_i;
  logic [width_p-1:0]      host_data_i;
  logic                    host_ready_o;
  logic                    host_v_o;
  logic [width_p-1:0]      host_data_o;
  logic                    host_err_o;
  logic                    host_yumi_i;

  // Accelerator compute engine
  logic                    accel_v_i;
  logic                    accel_w_i;
  logic [addr_width_p-1:0] accel_addr_i;
  logic [width_p-1:0]      accel_data_i;
  logic                    accel_ready_o;
  logic                    accel_v_o;
  logic [width_p-1:0]      accel_data_o;
  logic                    accel_err_o;
  logic                    accel_yumi_i;

  // Requester side: issues requests and consumes responses
  modport master (
    output host_v_i, host_w_i, host_addr_i, host_data_i, host_yumi_i,
    input  host_ready_o, host_v_o, host_data_o, host_err_o,
    output accel_v_i, accel_w_i, accel_addr_i, accel_data_i, accel_yumi_i,
    input  accel_ready_o, accel_v_o, accel_data_o, accel_err_o
  );

  // Arbiter side: accepts requests and returns responses
  modport slave (
    input  host_v_i, host_w_i, host_addr_i, host_data_i, host_yumi_i,
    output host_ready_o, host_v_o, host_data_o, host_err_o,
    input  accel_v_i, accel_w_i, accel_addr_i, accel_data_i, accel_yumi_i,
    output accel_ready_o, accel_v_o, accel_data_o, accel_err_o
  );
endinterface

// File: rtl/bp_sacc_spm_arbiter.sv
// Two-requester arbiter in front of the single-port sacc scratchpad.
// Host and accelerator share one 1rw SRAM with a 1-cycle read latency. There
// is at most one grant per cycle and at most one outstanding request per
// requester. Each accepted request gets exactly one response, which is
// presented the cycle after its grant and held until the requester takes it
// with yumi.
//
// Optional feature macro: BP_SACC_SPM_HOST_PRIO_EN
//   - defined: the host always wins a contended cycle, and no round-robin
//     state is built.
//   - undefined (default): round-robin between the two requesters. The
//     pointer advances only on a contended grant.
module bp_sacc_spm_arbiter #(
  parameter int els_p        = 20,
  parameter int width_p      = 64,
  parameter int addr_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_sacc_spm_arbiter_if.slave   bus,
  output logic [31:0]            conflict_cnt_o
);

  // Word index is the byte address with the 8-byte offset stripped. The full
  // index, including bits above the SRAM depth, takes part in the range check.
  localparam int idx_w_lp  = addr_width_p - 3;
  localparam int mem_aw_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [idx_w_lp-1:0] els_idx_lp = idx_w_lp'(els_p);

  // Requester index 0 = host, 1 = accelerator
  logic [1:0]                       req_v;
  logic [1:0]                       req_w;
  logic [1:0]                       req_yumi;
  logic [1:0][addr_width_p-1:0]     req_addr;
  logic [1:0][width_p-1:0]          req_data;

  logic [1:0][idx_w_lp-1:0]         req_idx;
  logic [1:0]                       in_range;
  logic [1:0]                       elig;
  logic [1:0]                       grant;
  logic                             contended;

  logic [1:0]                       resp_v;
  logic [1:0]                       resp_err;
  logic [1:0][width_p-1:0]          resp_data;

  // Single SRAM port
  logic                             sram_v;
  logic                             sram_w;
  logic [mem_aw_lp-1:0]             sram_addr;
  logic [width_p-1:0]               sram_wdata;
  logic [width_p-1:0]               sram_q;
  logic [width_p-1:0]               mem [els_p];

  logic [31:0]                      conflict_cnt_reg;

  // The byte offset within a word never affects the access
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{req_addr[0][2:0], req_addr[1][2:0]};

  assign req_v    = {bus.accel_v_i,    bus.host_v_i};
  assign req_w    = {bus.accel_w_i,    bus.host_w_i};
  assign req_yumi = {bus.accel_yumi_i, bus.host_yumi_i};
  assign req_addr = {bus.accel_addr_i, bus.host_addr_i};
  assign req_data = {bus.accel_data_i, bus.host_data_i};

  // Per-requester eligibility and response holding
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic               resp_v_reg;
    logic               fresh_reg;
    logic               rd_reg;
    logic               err_reg;
    logic [width_p-1:0] hold_reg;
    logic [width_p-1:0] fresh_data;

    assign req_idx[gi]  = req_addr[gi][addr_width_p-1:3];
    assign in_range[gi] = (req_idx[gi] < els_idx_lp);

    // A requester may be granted again in the same cycle its previous
    // response is consumed. Nothing is eligible while reset is held.
    assign elig[gi] = ~reset_i & req_v[gi]
                    & (~resp_v_reg | (resp_v_reg & req_yumi[gi]));

    // The SRAM output is only valid in the cycle right after the grant. It is
    // captured into hold_reg then, so later grants cannot disturb it.
    assign fresh_data = rd_reg ? sram_q : '0;

    // Outputs read as zero whenever no response is presented
    assign resp_v[gi]    = resp_v_reg & ~reset_i;
    assign resp_err[gi]  = resp_v[gi] & err_reg;
    assign resp_data[gi] = ~resp_v[gi] ? '0 : (fresh_reg ? fresh_data : hold_reg);

    // Response register: set on grant, cleared on yumi, data captured once
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        resp_v_reg <= 1'b0;
        fresh_reg  <= 1'b0;
        rd_reg     <= 1'b0;
        err_reg    <= 1'b0;
        hold_reg   <= '0;
      end else begin
        if (fresh_reg) begin
          hold_reg <= fresh_data;
        end
        if (grant[gi]) begin
          resp_v_reg <= 1'b1;
          fresh_reg  <= 1'b1;
          rd_reg     <= ~req_w[gi] & in_range[gi];
          err_reg    <= ~in_range[gi];
        end else begin
          fresh_reg <= 1'b0;
          if (resp_v_reg && req_yumi[gi]) begin
            resp_v_reg <= 1'b0;
          end
        end
      end
    end
  end

  assign contended = elig[0] & elig[1];

`ifdef BP_SACC_SPM_HOST_PRIO_EN
  // Fixed priority: the host wins every contended cycle
  always_comb begin
    grant = elig;
    if (contended) begin
      grant = 2'b01;
    end
  end
`else
  typedef enum logic {
    rr_host_e  = 1'b0,
    rr_accel_e = 1'b1
  } rr_e;

  rr_e rr_reg;
  rr_e rr_next;

  // Round-robin grant: the pointer names the favoured requester on contention
  always_comb begin
    grant   = elig;
    rr_next = rr_reg;
    if (contended) begin
      if (rr_reg == rr_host_e) begin
        grant   = 2'b01;
        rr_next = rr_accel_e;
      end else begin
        grant   = 2'b10;
        rr_next = rr_host_e;
      end
    end
  end

  // Round-robin pointer: starts with host, moves only on contended grants
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_reg <= rr_host_e;
    end else begin
      rr_reg <= rr_next;
    end
  end
`endif

  // SRAM port mux: the granted requester drives the port. Out-of-range
  // requests are granted so they still get an error response, but they never
  // enable the SRAM.
  always_comb begin
    sram_v     = 1'b0;
    sram_w     = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant[1]) begin
      sram_v     = in_range[1];
      sram_w     = req_w[1];
      sram_addr  = req_idx[1][mem_aw_lp-1:0];
      sram_wdata = req_data[1];
    end else if (grant[0]) begin
      sram_v     = in_range[0];
      sram_w     = req_w[0];
      sram_addr  = req_idx[0][mem_aw_lp-1:0];
      sram_wdata = req_data[0];
    end
  end

  // Single-port scratchpad with a registered read (block RAM style). A write
  // in cycle N is visible to a read granted in N+1 without any bypass.
  always_ff @(posedge clk_i) begin
    if (sram_v) begin
      if (sram_w) begin
        mem[sram_addr] <= sram_wdata;
      end else begin
        sram_q <= mem[sram_addr];
      end
    end
  end

  // Contention counter: saturates instead of wrapping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conflict_cnt_reg <= '0;
    end else if (contended && (conflict_cnt_reg != '1)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_reg;

  assign bus.host_ready_o  = grant[0];
  assign bus.host_v_o      = resp_v[0];
  assign bus.host_data_o   = resp_data[0];
  assign bus.host_err_o    = resp_err[0];

  assign bus.accel_ready_o = grant[1];
  assign bus.accel_v_o     = resp_v[1];
  assign bus.accel_data_o  = resp_data[1];
  assign bus.accel_err_o   = resp_err[1];

endmodule

// File: doc/bp_sacc_spm_arbiter.md
Name: bp_sacc_spm_arbiter

Overview:
Shares the accelerator's single-port synchronous scratchpad (1rw, 1-cycle read latency) between two requesters: the host IO path (uncached CSR/SPM accesses decoded upstream) and the accelerator compute engine.
- Arbitrates each cycle.
- Drives the single SRAM port.
- Returns exactly one response per accepted request to the originating requester, with per-requester backpressure.
- Sits between the IO command decoder and the SPM instance inside the sacc tile.

Parameters:
- els_p, 20: number of SPM words.
- width_p, 64: data width in bits.
- addr_width_p, 16: requester byte-address width. Word index = addr >> 3.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- host_v_i  in  1  host request valid
- host_w_i  in  1  1 = write, 0 = read
- host_addr_i  in  addr_width_p  host byte address
- host_data_i  in  width_p  host write data
- host_ready_o  out  1  host request accepted when host_v_i & host_ready_o
- host_v_o  out  1  host response valid
- host_data_o  out  width_p  host read data (0 for writes and errors)
- host_err_o  out  1  response corresponds to an out-of-range address
- host_yumi_i  in  1  host consumes response
- accel_v_i, accel_w_i, accel_addr_i, accel_data_i, accel_ready_o, accel_v_o, accel_data_o, accel_err_o, accel_yumi_i: same as host_*, for the accelerator port
- conflict_cnt_o  out  32  cycles in which both requesters were valid and eligible

Behaviour:
- Reset (synchronous, active-high):
  - host_v_o, accel_v_o, both err outputs, both data outputs, conflict_cnt_o = 0.
  - Round-robin pointer = host first.
  - A request in flight during reset is dropped; no response is issued.
- Eligibility: requester r is eligible when r_v_i & (~r_pending | (r_v_o & r_yumi_i)).
  - r_pending is set on grant and cleared on yumi.
  - At most one outstanding request per requester; a new grant is allowed in the same cycle the old response is consumed.
- Grant rules:
  - At most one grant per cycle.
  - One eligible requester: it is granted.
  - Both eligible: round-robin. The one not granted last time wins; the pointer advances only on a contended grant.
  - r_ready_o = grant_r (combinational, no dependence on r_v_i beyond eligibility).
- SRAM drive in grant cycle N:
  - v = 1, w = r_w_i, addr = word index, data = r_data_i.
  - Index >= els_p: SRAM not enabled, err flag latched.
- Response timing:
  - r_v_o rises in cycle N+1 for both reads and writes.
  - Read data is captured from the SRAM output in N+1 into a response register and held stable until yumi. SRAM output is not relied on after N+1.
  - Write response data = 0. Out-of-range response: data = 0, err = 1.
- Response handshake: yumi is legal only while r_v_o = 1. r_v_o deasserts the cycle after yumi unless a new grant occurred in the yumi cycle.
- Read-after-write: a read granted the cycle after a write to the same word, from either port, returns the new data. This follows from the SRAM ordering; no bypass is needed.
- conflict_cnt_o increments when both requesters are eligible in the same cycle. It saturates at all-ones and does not wrap.
- Address bits above the word index are ignored except for the range check.

Optional Feature:
BP_SACC_SPM_HOST_PRIO_EN
- Defined: fixed priority; host always wins when both are eligible. No round-robin pointer is built. conflict_cnt_o still counts.
- Undefined: round-robin as above.

Test Plan:
1. Host writes 0xDEADBEEF_00000001 at addr 0x18, then reads 0x18 -> write response at N+1 with data 0; read response at N+1 with data 0xDEADBEEF_00000001 and err = 0.
2. Both ports issue reads every cycle, with yumi held 1 and words 0..3 preloaded -> grants alternate host/accel, each port gets every other grant, conflict_cnt_o increments every contended cycle. With BP_SACC_SPM_HOST_PRIO_EN defined, accel is never granted.
3. Host reads word 2 (value 0x55) and holds host_yumi_i = 0 for 5 cycles while accel writes word 2 = 0x77 -> host_data_o stays 0x55 until yumi; host_ready_o = 0 throughout; accel proceeds unblocked.
4. Accel reads byte address 0xA0 (index 20, out of range) -> accel_v_o at N+1 with data 0, err = 1; no SRAM write occurs; a following read of word 19 is unaffected.
5. Back-to-back: host response valid with yumi = 1 and a new host request in the same cycle -> new grant that cycle; next response one cycle later; no lost or duplicated response.
6. reset_i asserted one cycle after a host read grant -> no host_v_o; all outputs 0 after reset; a subsequent request is served normally with RR pointer = host.
